// File: rtl/note_event_recorder.sv
// Multi-key note recorder: timestamps each press on a free-running tick counter and
// queues one {key_code, start, duration} event per release into a show-ahead FIFO.
module note_event_recorder #(
   parameter int NUM_KEYS       = 3,
   parameter int TIME_W         = 13,
   parameter int TICK_DIV       = 500000,
   parameter int FIFO_DEPTH     = 16,
   parameter int KEY_ACTIVE_LOW = 1,
   localparam int CODE_W = $clog2(NUM_KEYS + 1),
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [NUM_KEYS-1:0] keys,
   input  logic                rec_en,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [CODE_W-1:0]   evt_code,
   output logic [TIME_W-1:0]   evt_start,
   output logic [TIME_W-1:0]   evt_dur,
   output logic [TIME_W-1:0]   system_time,
   output logic [NUM_KEYS-1:0] held,
   output logic [CNT_W-1:0]    fifo_count,
   output logic                overflow
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int PRE_W = $clog2(TICK_DIV);
   localparam int ENT_W = CODE_W + 2 * TIME_W;
   localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(TICK_DIV - 1);

   logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, lvl_q, lvl_d, prev_q, prev_d;
   logic [2:0]          fill_q, fill_d;
   logic [PRE_W-1:0]    presc_q, presc_d;
   logic [TIME_W-1:0]   time_q, time_d;
   logic [NUM_KEYS-1:0] armed_q, armed_d, pending_q, pending_d;
   logic [TIME_W-1:0]   start_q [NUM_KEYS];
   logic [TIME_W-1:0]   start_d [NUM_KEYS];
   logic [TIME_W-1:0]   dur_q [NUM_KEYS];
   logic [TIME_W-1:0]   dur_d [NUM_KEYS];
   logic                ovf_q, ovf_d;
   logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]    mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic [NUM_KEYS-1:0] prs_e, rel_e;
   logic                push, wr, pop, full;
   logic [ENT_W-1:0]    push_ent;

   always_comb begin
      // Polarity is normalised ahead of the synchroniser so a cleared register means "not pressed".
      sync1_d = (KEY_ACTIVE_LOW != 0) ? ~keys : keys;
      sync2_d = sync1_q;
      lvl_d   = sync2_q;
      prev_d  = lvl_q;
      // Edges are ignored until the pipeline holds real samples, so a key held through reset never arms.
      fill_d  = fill_q[2] ? fill_q : fill_q + 3'd1;
      prs_e   = fill_q[2] ? (lvl_q & ~prev_q) : '0;
      rel_e   = fill_q[2] ? (~lvl_q & prev_q) : '0;

      if (presc_q == '0) begin
         presc_d = PRE_LOAD;
         time_d  = time_q + TIME_W'(1);
      end else begin
         presc_d = presc_q - PRE_W'(1);
         time_d  = time_q;
      end

      armed_d   = armed_q;
      start_d   = start_q;
      dur_d     = dur_q;
      ovf_d     = ovf_q;
      push      = 1'b0;
      push_ent  = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            push     = 1'b1;
            push_ent = {CODE_W'(i + 1), start_q[i], dur_q[i]};
         end
      end
      pending_d = pending_q & (pending_q - NUM_KEYS'(1));

      for (int i = 0; i < NUM_KEYS; i++) begin
         if (prs_e[i] && rec_en) begin
            start_d[i] = time_q;
            armed_d[i] = 1'b1;
         end
         if (rel_e[i] && armed_q[i]) begin
            armed_d[i] = 1'b0;
            if (pending_q[i]) begin
               ovf_d = 1'b1;
            end else begin
               dur_d[i]     = time_q - start_q[i];
               pending_d[i] = 1'b1;
            end
         end
      end

      full = (count_q == CNT_W'(FIFO_DEPTH));
      pop  = (count_q != '0) && evt_ready;
      wr   = push && (!full || pop);
      if (push && !wr) ovf_d = 1'b1;
      mem_d = mem_q;
      if (wr) mem_d[wptr_q] = push_ent;
      wptr_d  = wptr_q + PTR_W'(wr);
      rptr_d  = rptr_q + PTR_W'(pop);
      count_d = count_q + CNT_W'(wr) - CNT_W'(pop);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         lvl_q     <= '0;
         prev_q    <= '0;
         fill_q    <= '0;
         presc_q   <= PRE_LOAD;
         time_q    <= '0;
         armed_q   <= '0;
         pending_q <= '0;
         ovf_q     <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            start_q[i] <= '0;
            dur_q[i]   <= '0;
         end
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         lvl_q     <= lvl_d;
         prev_q    <= prev_d;
         fill_q    <= fill_d;
         presc_q   <= presc_d;
         time_q    <= time_d;
         armed_q   <= armed_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         start_q   <= start_d;
         dur_q     <= dur_d;
         mem_q     <= mem_d;
      end
   end

   assign evt_valid                       = (count_q != '0);
   assign {evt_code, evt_start, evt_dur}  = mem_q[rptr_q];
   assign system_time                     = time_q;
   assign held                            = armed_q;
   assign fifo_count                      = count_q;
   assign overflow                        = ovf_q;
endmodule

// File: tb/tb_note_event_recorder.sv
// Bench for note_event_recorder: random key timing checked against an event-level
// model (tick time from cycle count, expected-event queue).
module tb_note_event_recorder;
   localparam int NK = 3;
   localparam int TW = 4;
   localparam int TD = 4;
   localparam int FD = 4;
   localparam int CW = 2;
   localparam int NW = 3;

   logic          clock = 1'b0;
   logic          resetn = 1'b1;
   logic [NK-1:0] keys, held;
   logic [NK-1:0] pressed_v = '0;
   logic          rec_en = 1'b1, evt_ready = 1'b0;
   logic          evt_valid, overflow;
   logic [CW-1:0] evt_code;
   logic [TW-1:0] evt_start, evt_dur, system_time;
   logic [NW-1:0] fifo_count;

   int checks = 0;
   int errors = 0;
   int cyc;

   typedef struct { int code; int start; int dur; } evt_t;
   evt_t exp_q[$];
   int   m_start [NK];
   bit   m_armed [NK];

   note_event_recorder #(.NUM_KEYS(NK), .TIME_W(TW), .TICK_DIV(TD), .FIFO_DEPTH(FD),
                         .KEY_ACTIVE_LOW(1)) dut (
      .clock(clock), .resetn(resetn), .keys(keys), .rec_en(rec_en),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
      .evt_start(evt_start), .evt_dur(evt_dur), .system_time(system_time),
      .held(held), .fifo_count(fifo_count), .overflow(overflow));

   assign keys = ~pressed_v;
   always #5 clock = ~clock;

   always @(posedge clock or negedge resetn)
      if (!resetn) cyc <= 0;
      else cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // Tick time after n clock edges since reset release.
   function automatic int mt(input int n);
      return (n / TD) % (1 << TW);
   endfunction

   task automatic step(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic do_reset;
      evt_ready = 1'b0; rec_en = 1'b1; pressed_v = '0;
      foreach (m_armed[i]) m_armed[i] = 1'b0;
      exp_q.delete();
      @(posedge clock); #1 resetn = 1'b0;
      step(2);
      @(negedge clock); resetn = 1'b1;
   endtask

   // A pin change driven after edge c is seen at edge c+4, which uses the time after edge c+3.
   task automatic key_press(input int i);
      pressed_v[i] = 1'b1;
      if (rec_en) begin
         m_armed[i] = 1'b1;
         m_start[i] = mt(cyc + 3);
      end
   endtask

   task automatic key_release(input logic [NK-1:0] m);
      evt_t e;
      for (int i = 0; i < NK; i++) begin
         if (m[i]) begin
            pressed_v[i] = 1'b0;
            if (m_armed[i]) begin
               m_armed[i] = 1'b0;
               e.code  = i + 1;
               e.start = m_start[i];
               e.dur   = (mt(cyc + 3) - m_start[i]) & ((1 << TW) - 1);
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic test_reset;
      rec_en = 1'b1; evt_ready = 1'b0; pressed_v = '0;
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({evt_valid, evt_code, evt_start, evt_dur, system_time, held, fifo_count, overflow} !== '0) begin
         errors++; $display("FAIL reset_outputs: got %0h expected 0",
            {evt_valid, evt_code, evt_start, evt_dur, system_time, held, fifo_count, overflow});
      end
      step(3);
      @(negedge clock); resetn = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step(1);
         checks++;
         if (system_time !== TW'(mt(cyc))) begin
            errors++; $display("FAIL time_base: got %0d expected %0d", system_time, mt(cyc));
         end
      end
      checks++;
      if (system_time !== 4'd10) begin
         errors++; $display("FAIL idle_time: got %0d expected 10", system_time);
      end
      checks++;
      if ({evt_valid, fifo_count, overflow, held} !== '0) begin
         errors++; $display("FAIL idle_outputs: got %0h expected 0", {evt_valid, fifo_count, overflow, held});
      end
   endtask

   task automatic test_single;
      evt_t e;
      int nvalid;
      do_reset();
      step(5);
      key_press(1);
      step(3);
      checks++;
      if (held !== 3'b000) begin
         errors++; $display("FAIL held_early: got %b expected 000", held);
      end
      step(1);
      checks++;
      if (held !== 3'b010) begin
         errors++; $display("FAIL held_latency: got %b expected 010", held);
      end
      step(25 - cyc);
      key_release(3'b010);
      evt_ready = 1'b1;
      nvalid = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (evt_valid) begin
            nvalid++;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               if (evt_code !== CW'(e.code) || evt_start !== TW'(e.start) || evt_dur !== TW'(e.dur)) begin
                  errors++; $display("FAIL single_event: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     evt_code, evt_start, evt_dur, e.code, e.start, e.dur);
               end
            end
         end
      end
      checks++;
      if (nvalid != 1) begin
         errors++; $display("FAIL single_valid_cycles: got %0d expected 1", nvalid);
      end
      checks++;
      if (held !== 3'b000) begin
         errors++; $display("FAIL single_held_after: got %b expected 000", held);
      end
   endtask

   task automatic test_simultaneous;
      evt_t e;
      do_reset();
      step($urandom_range(1, 8));
      key_press(0); key_press(1); key_press(2);
      step(4);
      checks++;
      if (held !== 3'b111) begin
         errors++; $display("FAIL simul_held: got %b expected 111", held);
      end
      step($urandom_range(2, 30));
      key_release(3'b111);
      step(5);
      checks++;
      if (fifo_count !== 3'd1) begin
         errors++; $display("FAIL simul_count1: got %0d expected 1", fifo_count);
      end
      step(2);
      checks++;
      if (fifo_count !== 3'd3 || held !== 3'b000) begin
         errors++; $display("FAIL simul_count3: got count %0d held %b expected 3 and 000", fifo_count, held);
      end
      evt_ready = 1'b1;
      for (int k = 0; k < 16 && exp_q.size() > 0; k++) begin
         @(negedge clock);
         if (evt_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (evt_code !== CW'(e.code) || evt_start !== TW'(e.start) || evt_dur !== TW'(e.dur)) begin
               errors++; $display("FAIL simul_event: got %0d/%0d/%0d expected %0d/%0d/%0d",
                  evt_code, evt_start, evt_dur, e.code, e.start, e.dur);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL simul_drain: got %0d events left expected 0", exp_q.size());
      end
   endtask

   task automatic test_overflow;
      evt_t e;
      int k;
      do_reset();
      step(2);
      for (int p = 0; p < 5; p++) begin
         k = $urandom_range(0, NK - 1);
         key_press(k);
         step($urandom_range(3, 10));
         key_release(NK'(1 << k));
         step($urandom_range(6, 10));
         if (p == 3) begin
            checks++;
            if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
               errors++; $display("FAIL ovf_full: got count %0d ovf %b expected 4 and 0", fifo_count, overflow);
            end
         end
      end
      checks++;
      if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_drop: got count %0d ovf %b expected 4 and 1", fifo_count, overflow);
      end
      void'(exp_q.pop_back());   // the fifth event found the FIFO full
      evt_ready = 1'b1;
      for (int n = 0; n < 16 && exp_q.size() > 0; n++) begin
         @(negedge clock);
         if (evt_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (evt_code !== CW'(e.code) || evt_start !== TW'(e.start) || evt_dur !== TW'(e.dur)) begin
               errors++; $display("FAIL ovf_event: got %0d/%0d/%0d expected %0d/%0d/%0d",
                  evt_code, evt_start, evt_dur, e.code, e.start, e.dur);
            end
         end
      end
      step(1);
      checks++;
      if (exp_q.size() != 0 || evt_valid !== 1'b0 || overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_after: got left %0d valid %b ovf %b expected 0, 0, 1",
            exp_q.size(), evt_valid, overflow);
      end
   endtask

   task automatic test_full_push_pop;
      evt_t e;
      int k;
      do_reset();
      evt_ready = 1'b0;
      step(2);
      for (int p = 0; p < 4; p++) begin
         k = $urandom_range(0, NK - 1);
         key_press(k);
         step($urandom_range(3, 8));
         key_release(NK'(1 << k));
         step(8);
      end
      key_press(2);
      step($urandom_range(3, 8));
      key_release(3'b100);
      step(4);
      @(negedge clock);
      e = exp_q.pop_front();
      checks++;
      if (evt_valid !== 1'b1 || evt_code !== CW'(e.code) || evt_start !== TW'(e.start) || evt_dur !== TW'(e.dur)) begin
         errors++; $display("FAIL pp_head: got %b %0d/%0d/%0d expected 1 %0d/%0d/%0d",
            evt_valid, evt_code, evt_start, evt_dur, e.code, e.start, e.dur);
      end
      evt_ready = 1'b1;
      @(posedge clock); #1;
      evt_ready = 1'b0;
      step(2);
      checks++;
      if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
         errors++; $display("FAIL pp_count: got count %0d ovf %b expected 4 and 0", fifo_count, overflow);
      end
      evt_ready = 1'b1;
      for (int n = 0; n < 16 && exp_q.size() > 0; n++) begin
         @(negedge clock);
         if (evt_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (evt_code !== CW'(e.code) || evt_start !== TW'(e.start) || evt_dur !== TW'(e.dur)) begin
               errors++; $display("FAIL pp_event: got %0d/%0d/%0d expected %0d/%0d/%0d",
                  evt_code, evt_start, evt_dur, e.code, e.start, e.dur);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL pp_drain: got %0d events left expected 0", exp_q.size());
      end
   endtask

   task automatic test_wrap_rec_en;
      evt_t e;
      int n;
      do_reset();
      evt_ready = 1'b1;
      n = 0;
      while (mt(cyc + 3) != 14 && n < 200) begin step(1); n++; end
      key_press(0);
      step(4);
      n = 0;
      while (mt(cyc + 3) != 3 && n < 200) begin step(1); n++; end
      key_release(3'b001);
      for (int k = 0; k < 12 && exp_q.size() > 0; k++) begin
         @(negedge clock);
         if (evt_valid) begin
            e = exp_q.pop_front();
            checks++;
            if (evt_code !== CW'(e.code) || evt_start !== TW'(e.start) || evt_dur !== TW'(e.dur)) begin
               errors++; $display("FAIL wrap_event: got %0d/%0d/%0d expected %0d/%0d/%0d",
                  evt_code, evt_start, evt_dur, e.code, e.start, e.dur);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL wrap_drain: got %0d events left expected 0", exp_q.size());
      end
      rec_en = 1'b0;
      step(2);
      key_press(2);
      step(5);
      rec_en = 1'b1;
      step(5);
      checks++;
      if (held !== 3'b000) begin
         errors++; $display("FAIL recen_held: got %b expected 000", held);
      end
      key_release(3'b100);
      step(10);
      checks++;
      if (evt_valid !== 1'b0 || fifo_count !== 3'd0) begin
         errors++; $display("FAIL recen_event: got valid %b count %0d expected 0 and 0", evt_valid, fifo_count);
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      step(2);
      key_press(2);
      step(4);
      key_release(3'b100);
      step(3);
      key_press(0);
      step(6);
      checks++;
      if (evt_valid !== 1'b1 || held !== 3'b001) begin
         errors++; $display("FAIL mid_pre: got valid %b held %b expected 1 and 001", evt_valid, held);
      end
      #2 resetn = 1'b0;
      foreach (m_armed[i]) m_armed[i] = 1'b0;
      exp_q.delete();
      #1;
      checks++;
      if ({evt_valid, evt_code, evt_start, evt_dur, system_time, held, fifo_count, overflow} !== '0) begin
         errors++; $display("FAIL mid_outputs: got %0h expected 0",
            {evt_valid, evt_code, evt_start, evt_dur, system_time, held, fifo_count, overflow});
      end
      step(2);
      @(negedge clock); resetn = 1'b1;
      step(8);
      checks++;
      if (held !== 3'b000) begin
         errors++; $display("FAIL mid_held: got %b expected 000", held);
      end
      key_release(3'b001);
      step(10);
      checks++;
      if (evt_valid !== 1'b0 || fifo_count !== 3'd0 || exp_q.size() != 0) begin
         errors++; $display("FAIL mid_release: got valid %b count %0d expected 0 and 0", evt_valid, fifo_count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_overflow();
      test_full_push_pop();
      test_wrap_rec_en();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
